// File: rtl/fifo_n_guarded.sv
// fifo_n_guarded: parametrised guarded-method FIFO with a DEPTH-entry circular
// buffer and enq/deq/first methods guarded by __RDY/__ENA handshakes.
//
// Optional feature macro: FIFO_N_PIPELINE_EN
//   When defined, a full FIFO still accepts an enq while deq__ENA is high in
//   the same cycle. The new payload lands in the slot being vacated. This adds
//   a combinational path from deq__ENA to enq__RDY.
//   When undefined, enq__RDY depends on registered state only.
//
// Parameters:
//   WIDTH  payload width in bits, >= 1
//   DEPTH  number of entries, power of two, >= 2
//
// Ports:
//   CLK         clock, rising edge
//   nRST        synchronous active-low reset
//   enq__RDY    enq may fire this cycle
//   enq__ENA    enq fires (ignored while enq__RDY=0)
//   enq_v       enq payload
//   deq__RDY    deq may fire this cycle
//   deq__ENA    deq fires (ignored while deq__RDY=0)
//   first__RDY  head entry is valid
//   first       head entry payload, 0 when empty
//   count       occupancy, 0..DEPTH
module fifo_n_guarded #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic             CLK,
  input  logic             nRST,
  output logic             enq__RDY,
  input  logic             enq__ENA,
  input  logic [WIDTH-1:0] enq_v,
  output logic             deq__RDY,
  input  logic             deq__ENA,
  output logic             first__RDY,
  output logic [WIDTH-1:0] first,
  output logic [CW-1:0]    count
);

  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  // Storage (not reset) and control state.
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q,    cnt_d;

  logic not_empty;
  logic not_full;
  logic enq_rdy;
  logic enq_fire;
  logic deq_fire;

  // Guards derived from registered occupancy.
  assign not_empty = (cnt_q != '0);
  assign not_full  = (cnt_q != CNT_FULL);

`ifdef FIFO_N_PIPELINE_EN
  // A deq in the same cycle frees the head slot, so a full FIFO can take one more.
  assign enq_rdy = not_full | deq__ENA;
`else
  assign enq_rdy = not_full;
`endif

  assign enq_fire = enq__ENA & enq_rdy;
  assign deq_fire = deq__ENA & not_empty;

  // Method outputs.
  assign enq__RDY   = enq_rdy;
  assign deq__RDY   = not_empty;
  assign first__RDY = not_empty;
  assign first      = not_empty ? mem_q[rd_ptr_q] : '0;
  assign count      = cnt_q;

  // Next-state for storage: write the tail slot on enq.
  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      mem_d[i] = mem_q[i];
    end
    if (enq_fire) begin
      mem_d[wr_ptr_q] = enq_v;
    end
  end

  // Next-state for pointers and occupancy; full vs empty is told apart by cnt only.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (enq_fire) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (deq_fire) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    unique case ({enq_fire, deq_fire})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage array has no reset.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

  // Control state, synchronous active-low reset takes priority over any ENA.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_n_guarded.sv
// Directed bench for fifo_n_guarded at WIDTH=32, DEPTH=4.
module tb_fifo_n_guarded;

  logic        CLK;
  logic        nRST;
  logic        enq__RDY;
  logic        enq__ENA;
  logic [31:0] enq_v;
  logic        deq__RDY;
  logic        deq__ENA;
  logic        first__RDY;
  logic [31:0] first;
  logic [2:0]  count;

  int n_checks;
  int n_errors;

  fifo_n_guarded #(.WIDTH(32), .DEPTH(4)) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .enq__RDY   (enq__RDY),
    .enq__ENA   (enq__ENA),
    .enq_v      (enq_v),
    .deq__RDY   (deq__RDY),
    .deq__ENA   (deq__ENA),
    .first__RDY (first__RDY),
    .first      (first),
    .count      (count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of method enables, then settle #1 past the edge.
  task automatic cycle(input logic e, input logic d, input logic [31:0] v);
    enq__ENA = e;
    deq__ENA = d;
    enq_v    = v;
    @(posedge CLK);
    #1;
    enq__ENA = 1'b0;
    deq__ENA = 1'b0;
    enq_v    = 32'h0;
  endtask

  logic [31:0] exp_q[$];

  initial begin
    n_checks = 0;
    n_errors = 0;
    nRST     = 1'b0;
    enq__ENA = 1'b1;
    deq__ENA = 1'b1;
    enq_v    = 32'hEE;

    // 1. Reset held 2 cycles with both ENAs high.
    repeat (2) @(posedge CLK);
    #1;
    nRST     = 1'b1;
    enq__ENA = 1'b0;
    deq__ENA = 1'b0;
    enq_v    = 32'h0;
    #1;
    check("rst_count",   32'(count), 32'd0);
    check("rst_enq_rdy", 32'(enq__RDY), 32'd1);
    check("rst_deq_rdy", 32'(deq__RDY), 32'd0);
    check("rst_first_rdy", 32'(first__RDY), 32'd0);
    check("rst_first",   first, 32'h0);

    // 2. Fill, blocked fifth enq, drain.
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, 32'hA0 + 32'(i));
      check("fill_count", 32'(count), 32'(i + 1));
    end
    check("full_enq_rdy", 32'(enq__RDY), 32'd0);
    cycle(1'b1, 1'b0, 32'hFF);
    check("full_drop_count", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("drain_first", first, 32'hA0 + 32'(i));
      cycle(1'b0, 1'b1, 32'h0);
    end
    check("drain_count", 32'(count), 32'd0);
    check("drain_first_zero", first, 32'h0);

    // 3. Concurrent enq/deq at count=2 across the wrap.
    cycle(1'b1, 1'b0, 32'h10);
    cycle(1'b1, 1'b0, 32'h11);
    check("cc_start_count", 32'(count), 32'd2);
    exp_q = '{32'h10, 32'h11};
    for (int i = 0; i < 6; i++) begin
      check("cc_first", first, exp_q.pop_front());
      exp_q.push_back(32'h20 + 32'(i));
      cycle(1'b1, 1'b1, 32'h20 + 32'(i));
      check("cc_count", 32'(count), 32'd2);
    end
    check("cc_tail0", first, 32'h24);
    cycle(1'b0, 1'b1, 32'h0);
    check("cc_tail1", first, 32'h25);
    cycle(1'b0, 1'b1, 32'h0);
    check("cc_end_count", 32'(count), 32'd0);

    // 4. Enq while empty with deq also asserted; no bypass.
    enq__ENA = 1'b1;
    deq__ENA = 1'b1;
    enq_v    = 32'h55;
    #1;
    check("empty_first_nobypass", first, 32'h0);
    @(posedge CLK);
    #1;
    enq__ENA = 1'b0;
    deq__ENA = 1'b0;
    check("empty_count", 32'(count), 32'd1);
    check("empty_first", first, 32'h55);
    cycle(1'b0, 1'b1, 32'h0);
    check("empty_drain", 32'(count), 32'd0);

    // 5. Full, enq+deq in the same cycle.
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 32'hB0 + 32'(i));
    check("f5_count", 32'(count), 32'd4);
    enq__ENA = 1'b1;
    deq__ENA = 1'b1;
    enq_v    = 32'hC0;
    #1;
`ifdef FIFO_N_PIPELINE_EN
    check("f5_enq_rdy", 32'(enq__RDY), 32'd1);
`else
    check("f5_enq_rdy", 32'(enq__RDY), 32'd0);
`endif
    @(posedge CLK);
    #1;
    enq__ENA = 1'b0;
    deq__ENA = 1'b0;
    check("f5_first", first, 32'hB1);
`ifdef FIFO_N_PIPELINE_EN
    check("f5_count_after", 32'(count), 32'd4);
    exp_q = '{32'hB1, 32'hB2, 32'hB3, 32'hC0};
`else
    check("f5_count_after", 32'(count), 32'd3);
    exp_q = '{32'hB1, 32'hB2, 32'hB3};
`endif
    while (exp_q.size() > 0) begin
      check("f5_drain", first, exp_q.pop_front());
      cycle(1'b0, 1'b1, 32'h0);
    end
    check("f5_end_count", 32'(count), 32'd0);

    // 6. Reset mid-stream at count=3.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h60 + 32'(i));
    check("m6_count", 32'(count), 32'd3);
    nRST     = 1'b0;
    enq__ENA = 1'b1;
    enq_v    = 32'h99;
    @(posedge CLK);
    #1;
    nRST     = 1'b1;
    enq__ENA = 1'b0;
    check("m6_rst_count", 32'(count), 32'd0);
    check("m6_rst_deq_rdy", 32'(deq__RDY), 32'd0);
    check("m6_rst_first", first, 32'h0);
    cycle(1'b1, 1'b0, 32'h77);
    check("m6_first", first, 32'h77);
    check("m6_count_after", 32'(count), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fifo_n_guarded.md
# fifo_n_guarded

Parametrised guarded-method FIFO: the multi-entry, configurable-width successor of the single-entry `Fifo1` element. It has the same enq/deq/first method interface with `__RDY`/`__ENA` guards, adds a DEPTH-entry circular buffer, an occupancy output, and an optional full-pipeline mode. Generated method-level modules use it between pipeline stages wherever one slot of slack is not enough.

## Interface
Parameters:
- `WIDTH`, default 32: payload width in bits, ≥1.
- `DEPTH`, default 4: number of entries. Must be a power of two, ≥2. Pointer width is `AW = log2(DEPTH)`.

Ports:
- `CLK` in 1: clock; all state updates on the rising edge.
- `nRST` in 1: reset, synchronous, active-low.
- `enq__RDY` out 1: enq method may fire this cycle.
- `enq__ENA` in 1: enq fires; meaningful only while `enq__RDY`=1.
- `enq_v` in WIDTH: enq payload, sampled when enq fires.
- `deq__RDY` out 1: deq method may fire.
- `deq__ENA` in 1: deq fires; meaningful only while `deq__RDY`=1.
- `first__RDY` out 1: head entry is valid.
- `first` out WIDTH: head entry payload.
- `count` out AW+1: current occupancy, 0..DEPTH.

## Operation
- State:
  - Storage array `mem[DEPTH]` of WIDTH bits, not reset.
  - `wr_ptr` and `rd_ptr`, each AW bits, wrapping modulo DEPTH.
  - `cnt`, AW+1 bits.
- Effective fire signals:
  - `enq_fire = enq__ENA & enq__RDY`
  - `deq_fire = deq__ENA & deq__RDY`
  - An ENA asserted while its RDY is 0 is ignored: no state change and no error.
- On `enq_fire`: `mem[wr_ptr] <= enq_v`; `wr_ptr` increments.
- On `deq_fire`: `rd_ptr` increments. Storage contents are left unchanged.
- Count update:
  - enq only: +1.
  - deq only: −1.
  - Both or neither: unchanged.
- Guards:
  - `deq__RDY = first__RDY = (cnt != 0)`.
  - `enq__RDY = (cnt != DEPTH)`, subject to the Configuration section.
- `first = mem[rd_ptr]` when `cnt != 0`; otherwise `first` = 0.
- `count = cnt`.
- Wrap-around: pointers roll from DEPTH−1 to 0 with no special case. Full versus empty is distinguished only by `cnt`.
- Simultaneous enq and deq with 0 < cnt < DEPTH: both complete and `cnt` is unchanged.
- Empty: deq is blocked. An enq in the same cycle writes normally. There is no same-cycle bypass, so the payload is not visible on `first` until the next cycle.

## Timing
- Reset (nRST=0 at a rising edge): `wr_ptr`, `rd_ptr` and `cnt` go to 0. Until the first enq this gives:
  - `enq__RDY`=1
  - `deq__RDY`=0, `first__RDY`=0
  - `first`=0, `count`=0
- Reset takes priority over any ENA in the same cycle. A reset in the middle of operation discards all entries.
- Guard and data outputs are combinational from registered state only. There is no path from ENA to RDY, except `enq__RDY` when `FIFO_N_PIPELINE_EN` is defined.
- Latency is 1 cycle: an entry enqueued at edge N is visible on `first` with `first__RDY`=1 after edge N.
- Throughput is one enq and one deq per cycle at steady state.

## Configuration
- Macro: `FIFO_N_PIPELINE_EN`.
- Defined:
  - `enq__RDY = (cnt != DEPTH) | deq__ENA`.
  - When full, an enq accompanied by a deq in the same cycle is accepted. The write lands in the slot being vacated, and `cnt` stays at DEPTH.
  - This adds a combinational path from `deq__ENA` to `enq__RDY`.
- Undefined:
  - `enq__RDY = (cnt != DEPTH)`.
  - When full, enq is blocked even if a deq fires in the same cycle.

## Test plan
Benches use WIDTH=32, DEPTH=4.

1. **Reset.** Hold nRST=0 for 2 cycles with both ENAs high, then release. Required: `count`=0, `enq__RDY`=1, `deq__RDY`=0, `first`=0.
2. **Fill, then drain with wrap.** Enq 0xA0..0xA3 on consecutive cycles. Required: `count` reads 4, `enq__RDY`=0, and a fifth enq of 0xFF is ignored. Deq 4 times. Required: `first` reads 0xA0, 0xA1, 0xA2, 0xA3, then `count`=0.
3. **Concurrent enq/deq.** Start with count=2 holding 0x10, 0x11. Run enq+deq for 6 cycles with enq data 0x20..0x25. Required: `count` stays at 2 throughout, and `first` shows the sequence 0x10, 0x11, 0x20, … in order across the pointer wrap.
4. **Enq while empty.** Enq 0x55 while empty, with `deq__ENA` also high. Required: deq is ignored, and on the next cycle `first`=0x55 and `count`=1.
5. **Full, enq+deq.** Start full with 0xB0..0xB3, then enq 0xC0 with deq asserted in the same cycle.
   - With `FIFO_N_PIPELINE_EN` defined: `count` stays at 4, `first`=0xB1, and 0xC0 dequeues fourth.
   - With it undefined: `count`=3 and 0xC0 is dropped.
6. **Reset mid-stream.** Assert nRST=0 with count=3. Required: after the edge, `count`=0 and `deq__RDY`=0, and a subsequent enq of 0x77 is the next value on `first`.
